cc_tag_checker: RTL and testbench
=================================

Name: cc_tag_checker

Overview:
- Lookup stage directly downstream of the cache-controller address decoder.
- Consumes the decoder's handshake pulse and split tag/index/offset, and reads the tag SRAM and data SRAM.
- Resolves hit/miss against a 512-entry valid array held in flops, then pushes results into the hit-flag, hit-data, miss-address and miss-request FIFOs. The decoder throttles on those FIFOs' almost-full flags.
- Also owns the tag-write/fill path and the flush path.

Parameters:
TAG_W, 17, tag width (addr[31:15])
IDX_W, 9, index width (addr[14:6]); 2^IDX_W lines
OFF_W, 6, byte offset width (addr[5:0])
DATA_W, 512, cache line width in bits

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
hs_pulse_i  input  1  decoder AR handshake accepted this cycle
tag_i  input  TAG_W  lookup tag
index_i  input  IDX_W  lookup index
offset_i  input  OFF_W  lookup offset
tag_rd_en_o  output  1  tag SRAM read enable (sync read, 1-cycle latency)
tag_rd_idx_o  output  IDX_W  tag SRAM read index
tag_rd_data_i  input  TAG_W  tag SRAM read data, valid cycle after rd_en
data_rd_en_o  output  1  data SRAM read enable (sync read, 1-cycle latency)
data_rd_idx_o  output  IDX_W  data SRAM read index
data_rd_data_i  input  DATA_W  data SRAM line, valid cycle after rd_en
fill_valid_i  input  1  refill writes line tag this cycle
fill_index_i  input  IDX_W  refill index
fill_tag_i  input  TAG_W  refill tag
tag_wr_en_o  output  1  tag SRAM write enable
tag_wr_idx_o  output  IDX_W  tag SRAM write index
tag_wr_data_o  output  TAG_W  tag SRAM write data
flush_i  input  1  invalidate all lines
hit_flag_wren_o  output  1  push hit-flag FIFO
hit_flag_o  output  1  1 = hit, 0 = miss
hit_data_wren_o  output  1  push hit-data FIFO
hit_data_o  output  DATA_W  hit line data
hit_off_o  output  OFF_W  offset accompanying hit data
miss_addr_wren_o  output  1  push miss-address FIFO
miss_addr_o  output  32  full miss address {tag,index,offset}
miss_req_wren_o  output  1  push miss-request FIFO
miss_req_o  output  32  line-aligned miss address {tag,index,6'b0}
hit_cnt_o  output  32  hit counter
miss_cnt_o  output  32  miss counter

Behaviour:
- Reset (rst_n=0, async): valid array all 0, pipeline valids 0, every FIFO wren 0, all data outputs 0, counters 0. A reset mid-lookup drops in-flight lookups; no FIFO push occurs for them.
- Lookup pipeline: in-order, non-stalling. Every hs_pulse_i is accepted; the decoder's almost-full margin guarantees FIFO room. Throughput is 1 lookup/cycle.
- S0 (cycle T):
  - tag_rd_en_o = data_rd_en_o = hs_pulse_i; tag_rd_idx_o = data_rd_idx_o = index_i (combinational).
  - On hs_pulse_i, register s1_v, tag, index, offset.
  - Also register fwd = fill_valid_i && fill_index_i==index_i, plus fill_tag_i.
- S1 (T+1):
  - line_tag = fwd ? fwd_tag : tag_rd_data_i.
  - line_valid = fwd | valid_q[s1_index].
  - hit = line_valid && line_tag==s1_tag.
  - Results are registered into S2.
- S2 (T+2), outputs asserted for exactly 1 cycle per lookup:
  - Always: hit_flag_wren_o=1, hit_flag_o=hit.
  - Hit: hit_data_wren_o=1, hit_data_o = data_rd_data_i captured at T+1, hit_off_o=offset; hit_cnt_o increments.
  - Miss: miss_addr_wren_o=1 and miss_req_wren_o=1 with miss_addr_o and miss_req_o as defined in Ports; miss_cnt_o increments.
  - Non-pushed data outputs hold their last value.
- Latency hs_pulse_i → FIFO push is exactly 2 cycles.
- Fill path:
  - tag_wr_en_o/idx/data = fill_valid_i/fill_index_i/fill_tag_i, combinational.
  - valid_q[fill_index_i] is set at the clock edge.
  - Tag SRAM read-during-write returns old data; S0 forwarding covers a fill to the same index in the same cycle as the lookup.
  - A fill in the same cycle as that index's S1 compare does not affect that lookup (lookup ordered first).
- Flush:
  - flush_i clears all valid_q at the edge.
  - A lookup already in S1 during the flush cycle uses pre-flush state.
  - Flush and fill in the same cycle: all cleared, then the fill index is set (fill wins).
- Counters are 32-bit and wrap from 0xFFFF_FFFF to 0.
- No internal stall or backpressure. Assertion: a FIFO push never coincides with an unexpected X on hit.

Test Plan:
- Reset, then hs_pulse_i with tag=0x00001, index=0x005, offset=0x10 → at T+2: hit_flag_wren_o=1, hit_flag_o=0, miss_addr_o=0x0000_8150, miss_req_o=0x0000_8140, miss_cnt_o=1, hit_data_wren_o=0.
- Fill index=0x005, tag=0x00001; two cycles later lookup the same address with SRAM model returning 0x00001 and data 0xA5.. → T+2: hit_flag_o=1, hit_data_o=0xA5.., hit_off_o=0x10, hit_cnt_o=1.
- Fill and lookup to index 0x1FF in the same cycle, SRAM returning stale tag 0x1FFFF, fill_tag=0x0ABCD, lookup tag 0x0ABCD → hit via forwarding; lookup tag 0x1FFFF → miss.
- Back-to-back hs_pulse_i for 4 cycles, alternating hit/miss indices → 4 consecutive hit_flag pushes in order 1,0,1,0 at T+2..T+5; hit_cnt_o=2, miss_cnt_o=2.
- Line valid, then flush_i and fill(index 3) in the same cycle → next lookup index 3 hits, index 5 misses; a lookup in S1 during the flush cycle still hits.
- Assert rst_n=0 at T+1 of an in-flight lookup → no FIFO wren at T+2; all outputs and counters 0.

Source files
------------

// File: rtl/cc_tag_checker.sv
// Tag-lookup stage behind the cache-controller address decoder: resolves hit/miss
// against the tag SRAM and a flop-based valid array, and pushes results into the result FIFOs.
module cc_tag_checker #(
  parameter int TAG_W  = 17,
  parameter int IDX_W  = 9,
  parameter int OFF_W  = 6,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              hs_pulse_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [OFF_W-1:0]  offset_i,

  output logic              tag_rd_en_o,
  output logic [IDX_W-1:0]  tag_rd_idx_o,
  input  logic [TAG_W-1:0]  tag_rd_data_i,
  output logic              data_rd_en_o,
  output logic [IDX_W-1:0]  data_rd_idx_o,
  input  logic [DATA_W-1:0] data_rd_data_i,

  input  logic              fill_valid_i,
  input  logic [IDX_W-1:0]  fill_index_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  output logic              tag_wr_en_o,
  output logic [IDX_W-1:0]  tag_wr_idx_o,
  output logic [TAG_W-1:0]  tag_wr_data_o,

  input  logic              flush_i,

  output logic              hit_flag_wren_o,
  output logic              hit_flag_o,
  output logic              hit_data_wren_o,
  output logic [DATA_W-1:0] hit_data_o,
  output logic [OFF_W-1:0]  hit_off_o,
  output logic              miss_addr_wren_o,
  output logic [31:0]       miss_addr_o,
  output logic              miss_req_wren_o,
  output logic [31:0]       miss_req_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int LINES = 1 << IDX_W;

  // S0: SRAM read and tag write ports are straight pass-throughs.
  assign tag_rd_en_o   = hs_pulse_i;
  assign tag_rd_idx_o  = index_i;
  assign data_rd_en_o  = hs_pulse_i;
  assign data_rd_idx_o = index_i;
  assign tag_wr_en_o   = fill_valid_i;
  assign tag_wr_idx_o  = fill_index_i;
  assign tag_wr_data_o = fill_tag_i;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;

  // NOTE: combinational blocks use blocking '=' so later statements see earlier
  // ones (flush clears first, then the fill bit is set); flops use '<=' only.
  always_comb begin
    valid_d = flush_i ? '0 : valid_q;
    if (fill_valid_i) valid_d[fill_index_i] = 1'b1;
  end

  // NOTE: the valid array is plain flops rather than SRAM, so it takes the
  // async reset like any other state; the tag/data SRAMs are never reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // S1 registers. The fill tag is captured alongside the lookup because the
  // tag SRAM returns pre-write data when a fill hits the same index this cycle.
  logic              s1_v;
  logic [TAG_W-1:0]  s1_tag;
  logic [IDX_W-1:0]  s1_index;
  logic [OFF_W-1:0]  s1_off;
  logic              s1_fwd;
  logic [TAG_W-1:0]  s1_fwd_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1_tag     <= '0;
      s1_index   <= '0;
      s1_off     <= '0;
      s1_fwd     <= 1'b0;
      s1_fwd_tag <= '0;
    end else begin
      s1_v <= hs_pulse_i;
      if (hs_pulse_i) begin
        s1_tag     <= tag_i;
        s1_index   <= index_i;
        s1_off     <= offset_i;
        s1_fwd     <= fill_valid_i && (fill_index_i == index_i);
        s1_fwd_tag <= fill_tag_i;
      end
    end
  end

  logic [TAG_W-1:0] line_tag;
  logic             line_valid;
  logic             s1_hit;

  // valid_q is read before this edge's fill/flush lands, so a same-cycle
  // fill or flush never affects the lookup currently in S1.
  always_comb begin
    line_tag   = s1_fwd ? s1_fwd_tag : tag_rd_data_i;
    line_valid = s1_fwd | valid_q[s1_index];
    s1_hit     = line_valid && (line_tag == s1_tag);
  end

  // S2: registered FIFO pushes; data outputs hold between pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_flag_wren_o  <= 1'b0;
      hit_flag_o       <= 1'b0;
      hit_data_wren_o  <= 1'b0;
      hit_data_o       <= '0;
      hit_off_o        <= '0;
      miss_addr_wren_o <= 1'b0;
      miss_addr_o      <= '0;
      miss_req_wren_o  <= 1'b0;
      miss_req_o       <= '0;
      hit_cnt_o        <= '0;
      miss_cnt_o       <= '0;
    end else begin
      hit_flag_wren_o  <= s1_v;
      hit_data_wren_o  <= s1_v && s1_hit;
      miss_addr_wren_o <= s1_v && !s1_hit;
      miss_req_wren_o  <= s1_v && !s1_hit;
      if (s1_v) hit_flag_o <= s1_hit;
      if (s1_v && s1_hit) begin
        hit_data_o <= data_rd_data_i;
        hit_off_o  <= s1_off;
        hit_cnt_o  <= hit_cnt_o + 32'd1;
      end
      if (s1_v && !s1_hit) begin
        miss_addr_o <= {s1_tag, s1_index, s1_off};
        miss_req_o  <= {s1_tag, s1_index, {OFF_W{1'b0}}};
        miss_cnt_o  <= miss_cnt_o + 32'd1;
      end
    end
  end

  a_flag_known: assert property (@(posedge clk) disable iff (!rst_n)
    hit_flag_wren_o |-> !$isunknown(hit_flag_o));

endmodule

// File: tb/tb_cc_tag_checker.sv
// Directed + randomized bench for cc_tag_checker with a behavioural cache model
// and a simple tag/data SRAM model in the bench.
module tb_cc_tag_checker;

  localparam int TAG_W  = 17;
  localparam int IDX_W  = 9;
  localparam int OFF_W  = 6;
  localparam int DATA_W = 512;
  localparam int LINES  = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hs_pulse;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  index;
  logic [OFF_W-1:0]  offset;
  logic              tag_rd_en, data_rd_en;
  logic [IDX_W-1:0]  tag_rd_idx, data_rd_idx;
  logic [TAG_W-1:0]  tag_rd_data;
  logic [DATA_W-1:0] data_rd_data;
  logic              fill_valid;
  logic [IDX_W-1:0]  fill_index;
  logic [TAG_W-1:0]  fill_tag;
  logic              tag_wr_en;
  logic [IDX_W-1:0]  tag_wr_idx;
  logic [TAG_W-1:0]  tag_wr_data;
  logic              flush;
  logic              hit_flag_wren, hit_flag, hit_data_wren, miss_addr_wren, miss_req_wren;
  logic [DATA_W-1:0] hit_data;
  logic [OFF_W-1:0]  hit_off;
  logic [31:0]       miss_addr, miss_req, hit_cnt, miss_cnt;

  cc_tag_checker #(.TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .hs_pulse_i(hs_pulse), .tag_i(tag), .index_i(index), .offset_i(offset),
    .tag_rd_en_o(tag_rd_en), .tag_rd_idx_o(tag_rd_idx), .tag_rd_data_i(tag_rd_data),
    .data_rd_en_o(data_rd_en), .data_rd_idx_o(data_rd_idx), .data_rd_data_i(data_rd_data),
    .fill_valid_i(fill_valid), .fill_index_i(fill_index), .fill_tag_i(fill_tag),
    .tag_wr_en_o(tag_wr_en), .tag_wr_idx_o(tag_wr_idx), .tag_wr_data_o(tag_wr_data),
    .flush_i(flush),
    .hit_flag_wren_o(hit_flag_wren), .hit_flag_o(hit_flag),
    .hit_data_wren_o(hit_data_wren), .hit_data_o(hit_data), .hit_off_o(hit_off),
    .miss_addr_wren_o(miss_addr_wren), .miss_addr_o(miss_addr),
    .miss_req_wren_o(miss_req_wren), .miss_req_o(miss_req),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  // SRAM models: synchronous read, read-during-write returns old data.
  logic [TAG_W-1:0] tmem [LINES];
  logic             bd_en = 1'b0;
  logic [IDX_W-1:0] bd_idx = '0;
  logic [TAG_W-1:0] bd_tag = '0;

  function automatic logic [DATA_W-1:0] line_data(input logic [IDX_W-1:0] i);
    if (i == 9'h005) return {64{8'hA5}};
    return {16{32'hC0DE_0000 ^ (32'(i) * 32'h9E37_79B1)}};
  endfunction

  always @(posedge clk) begin
    if (tag_rd_en)  tag_rd_data  <= tmem[tag_rd_idx];
    if (data_rd_en) data_rd_data <= line_data(data_rd_idx);
    if (bd_en)      tmem[bd_idx] <= bd_tag;
    if (tag_wr_en)  tmem[tag_wr_idx] <= tag_wr_data;
  end

  // Behavioural cache model and expected-result scoreboard.
  typedef struct {
    int                due;
    bit                hit;
    logic [DATA_W-1:0] data;
    logic [OFF_W-1:0]  off;
    logic [31:0]       addr;
  } exp_t;

  exp_t              exp_q[$];
  bit                mvalid [LINES];
  logic [TAG_W-1:0]  mtag   [LINES];
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;
  logic              last_flag;
  logic [DATA_W-1:0] last_data;
  logic [OFF_W-1:0]  last_off;
  logic [31:0]       last_maddr, last_mreq, exp_hcnt, exp_mcnt;

  task automatic check(input string name, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    last_flag = 1'b0; last_data = '0; last_off = '0;
    last_maddr = '0; last_mreq = '0; exp_hcnt = '0; exp_mcnt = '0;
  endtask

  task automatic check_outputs();
    exp_t e;
    bit   push;
    push = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (push) begin
      e = exp_q.pop_front();
      last_flag = e.hit;
      if (e.hit) begin
        last_data = e.data; last_off = e.off; exp_hcnt = exp_hcnt + 32'd1;
      end else begin
        last_maddr = e.addr; last_mreq = e.addr & 32'hFFFF_FFC0; exp_mcnt = exp_mcnt + 32'd1;
      end
    end
    check("hit_flag_wren",  hit_flag_wren,  push);
    check("hit_data_wren",  hit_data_wren,  push && e.hit);
    check("miss_addr_wren", miss_addr_wren, push && !e.hit);
    check("miss_req_wren",  miss_req_wren,  push && !e.hit);
    check("hit_flag",  hit_flag,  last_flag);
    check("hit_data",  hit_data,  last_data);
    check("hit_off",   hit_off,   last_off);
    check("miss_addr", miss_addr, last_maddr);
    check("miss_req",  miss_req,  last_mreq);
    check("hit_cnt",   hit_cnt,   exp_hcnt);
    check("miss_cnt",  miss_cnt,  exp_mcnt);
  endtask

  // One clock cycle: drive at negedge, update the model, sample 1ns after posedge.
  // A lookup sees the cache state after this cycle's flush/fill (fill wins).
  task automatic step(input bit hs, input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                      input logic [OFF_W-1:0] o, input bit fv, input logic [IDX_W-1:0] fi,
                      input logic [TAG_W-1:0] ft, input bit fl);
    exp_t e;
    @(negedge clk);
    hs_pulse = hs; tag = t; index = i; offset = o;
    fill_valid = fv; fill_index = fi; fill_tag = ft; flush = fl;
    #1;
    check("tag_rd_en", tag_rd_en, hs);
    check("tag_wr_en", tag_wr_en, fv);
    if (fl) for (int k = 0; k < LINES; k++) mvalid[k] = 1'b0;
    if (fv) begin mvalid[fi] = 1'b1; mtag[fi] = ft; end
    if (hs) begin
      e.due  = cyc + 2;
      e.hit  = mvalid[i] && (mtag[i] == t);
      e.data = line_data(i);
      e.off  = o;
      e.addr = {t, i, o};
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic lookup(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i, input logic [OFF_W-1:0] o);
    step(1, t, i, o, 0, '0, '0, 0);
  endtask

  task automatic fill(input logic [IDX_W-1:0] i, input logic [TAG_W-1:0] t);
    step(0, '0, '0, '0, 1, i, t, 0);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst_n = 1'b0; hs_pulse = 1'b0; fill_valid = 1'b0; flush = 1'b0;
    model_clear();
    @(posedge clk); #1;
    cyc++;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stale_tag(input logic [IDX_W-1:0] i, input logic [TAG_W-1:0] t);
    @(negedge clk);
    bd_en = 1'b1; bd_idx = i; bd_tag = t;
    @(posedge clk); #1;
    cyc++;
    check_outputs();
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  initial begin
    logic [IDX_W-1:0] ri, rfi;
    logic [TAG_W-1:0] rt;
    rst_n = 1'b0; hs_pulse = 1'b0; tag = '0; index = '0; offset = '0;
    fill_valid = 1'b0; fill_index = '0; fill_tag = '0; flush = 1'b0;
    for (int i = 0; i < LINES; i++) mtag[i] = '0;
    model_clear();
    reset_cycle();
    reset_cycle();

    // Cold miss: miss_addr 0x8150, miss_req 0x8140.
    lookup(17'h00001, 9'h005, 6'h10);
    idle(3);

    // Fill then hit with 0xA5.. data.
    fill(9'h005, 17'h00001);
    idle(1);
    lookup(17'h00001, 9'h005, 6'h10);
    idle(3);

    // Same-cycle fill forwarding over a stale tag SRAM at the top index.
    stale_tag(9'h1FF, 17'h1FFFF);
    step(1, 17'h1FFFF, 9'h1FF, 6'h3F, 1, 9'h1FF, 17'h0ABCD, 0);
    idle(3);
    stale_tag(9'h1FF, 17'h1FFFF);
    step(1, 17'h0ABCD, 9'h1FF, 6'h00, 1, 9'h1FF, 17'h0ABCD, 0);
    idle(3);

    // Back-to-back hit/miss/hit/miss.
    lookup(17'h00001, 9'h005, 6'h01);
    lookup(17'h00001, 9'h006, 6'h02);
    lookup(17'h00001, 9'h005, 6'h03);
    lookup(17'h00001, 9'h006, 6'h04);
    idle(3);

    // Flush with same-cycle fill; the lookup in S1 during the flush still hits.
    fill(9'h003, 17'h00003);
    idle(1);
    lookup(17'h00001, 9'h005, 6'h08);
    step(0, '0, '0, '0, 1, 9'h003, 17'h00003, 1);
    lookup(17'h00003, 9'h003, 6'h09);
    lookup(17'h00001, 9'h005, 6'h0A);
    idle(3);

    // Reset while a lookup is in S1: no push, everything back to zero.
    lookup(17'h00003, 9'h003, 6'h11);
    reset_cycle();
    idle(3);

    // Randomized traffic over a small index pool to provoke hits and collisions.
    for (int n = 0; n < 400; n++) begin
      ri  = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'(9'h1F8 + $urandom_range(0, 7));
      rt  = ($urandom_range(0, 1) != 0) ? mtag[ri] : 17'($urandom_range(0, 3));
      rfi = ($urandom_range(0, 1) != 0) ? ri : 9'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, rt, ri, 6'($urandom),
           $urandom_range(0, 3) == 0, rfi, 17'($urandom_range(0, 3)),
           $urandom_range(0, 39) == 0);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
